// File: rtl/pe_operand_feeder.sv
// Operand feeder for one systolic-array lane: buffers (x,w) pairs, waits a skew delay,
// issues one pair per PE handshake and reports done once every issued product has returned.
module pe_operand_feeder #(
    parameter int DEPTH  = 16,
    parameter int K_MAX  = 64,
    parameter int SKEW_W = 6,
    localparam int CW    = $clog2(K_MAX + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_x,
    input  logic [31:0]       ld_w,
    input  logic              ld_last,
    input  logic              go,
    input  logic [SKEW_W-1:0] skew_i,
    output logic [31:0]       x_o,
    output logic [31:0]       w_o,
    output logic              input_start,
    input  logic              stall_i,
    input  logic              data_ready_i,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CW-1:0]     issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 65;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] K_LAST   = CW'(K_MAX - 1);
    localparam logic [CW-1:0] CNT_INC  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKEW  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Handshakes: a load is accepted when ld_valid && ld_ready at a rising edge; a pair is
    // transferred to the PE when input_start && !stall_i at a rising edge.

    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    state_t            state_q, state_d;
    logic [SKEW_W-1:0] skew_cnt_q, skew_cnt_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     result_q, result_d;
    logic              err_q, err_d;

    logic          empty;
    logic          push;
    logic          xfer;
    logic          k_hit;
    logic [EW-1:0] head;

    assign empty    = (count_q == '0);
    assign ld_ready = (count_q != FULL_CNT);
    assign push     = ld_valid && ld_ready;
    assign head     = mem_q[rd_ptr_q];
    assign xfer     = input_start && !stall_i;
    assign k_hit    = (issued_q == K_LAST);

    assign x_o          = empty ? 32'd0 : head[63:32];
    assign w_o          = empty ? 32'd0 : head[31:0];
    assign err          = err_q;
    assign issued_count = issued_q;

    // Storage carries no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ld_last, ld_x, ld_w};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !xfer) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && xfer) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        issued_d   = issued_q;
        result_d   = result_q;
        err_d      = err_q;
        skew_cnt_d = skew_cnt_q;
        if (state_q == S_IDLE && go) begin
            issued_d   = '0;
            result_d   = '0;
            skew_cnt_d = skew_i;
        end
        if (state_q == S_SKEW) begin
            skew_cnt_d = skew_cnt_q - SKEW_W'(1);
        end
        if (xfer) begin
            issued_d = issued_q + CNT_INC;
            if (k_hit && !head[EW-1]) begin
                err_d = 1'b1;
            end
        end
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && data_ready_i) begin
            result_d = result_q + CNT_INC;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            skew_cnt_q <= '0;
            issued_q   <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            skew_cnt_q <= skew_cnt_d;
            issued_q   <= issued_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    // DRAIN looks at result_d so done follows the final data_ready by exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (skew_i == '0) ? S_ISSUE : S_SKEW;
                end
            end
            S_SKEW: begin
                if (skew_cnt_q <= SKEW_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (xfer && (head[EW-1] || k_hit)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (result_d == issued_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        input_start = (state_q == S_ISSUE) && !empty;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: loads pair vectors, drives a PE model with a
// configurable stall and fixed result latency, and scoreboards every transfer in order.
module tb_pe_operand_feeder;

    localparam int PE_LAT = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_x;
    logic [31:0] ld_w;
    logic        ld_last;
    logic        go;
    logic [5:0]  skew_i;
    logic [31:0] x_o;
    logic [31:0] w_o;
    logic        input_start;
    logic        stall_i;
    logic        data_ready_i;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  issued_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pe_stall = 0;
    int stall_cnt = 0;
    int last_dr_cyc = -100;
    logic [7:0]  dr_pipe;
    logic [63:0] exp_q [$];

    logic        prev_stalled = 1'b0;
    logic        prev_done    = 1'b0;
    logic [31:0] prev_x = '0;
    logic [31:0] prev_w = '0;

    pe_operand_feeder #(.DEPTH(16), .K_MAX(64), .SKEW_W(6)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_x        (ld_x),
        .ld_w        (ld_w),
        .ld_last     (ld_last),
        .go          (go),
        .skew_i      (skew_i),
        .x_o         (x_o),
        .w_o         (w_o),
        .input_start (input_start),
        .stall_i     (stall_i),
        .data_ready_i(data_ready_i),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .issued_count(issued_count)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout, expected test end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // PE model: stalls pe_stall cycles per op, returns data_ready PE_LAT cycles after transfer
    always @(negedge clk) begin
        if (!n_rst) begin
            stall_i      = 1'b0;
            data_ready_i = 1'b0;
            dr_pipe      = '0;
            stall_cnt    = 0;
        end else begin
            data_ready_i = dr_pipe[0];
            if (dr_pipe[0]) last_dr_cyc = cyc;
            dr_pipe = dr_pipe >> 1;
            if (input_start && stall_cnt < pe_stall) begin
                stall_i = 1'b1;
                stall_cnt++;
            end else begin
                stall_i = 1'b0;
                if (input_start) begin
                    stall_cnt = 0;
                    dr_pipe[PE_LAT-1] = 1'b1;
                end
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (!n_rst) begin
            prev_stalled = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (prev_stalled) begin
                chk("stall_hold", {31'd0, input_start, x_o, w_o}, {31'd0, 1'b1, prev_x, prev_w});
            end
            if (input_start && !stall_i) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", {x_o, w_o}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_data", {x_o, w_o}, e);
                end
            end
            prev_stalled = input_start && stall_i;
            prev_x = x_o;
            prev_w = w_o;
            if (done) begin
                chk("done_single_pulse", prev_done, 0);
                chk("done_after_data_ready", cyc - last_dr_cyc, 1);
            end
            prev_done = done;
        end
    end

    // driver tasks
    task automatic load_pair(input logic [31:0] x, input logic [31:0] w, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_x     = x;
        ld_w     = w;
        ld_last  = last;
        while (!ld_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) fail_wait("load_timeout");
        else exp_q.push_back({x, w});
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic load_vec(input logic [31:0] bx, input logic [31:0] bw, input int first,
                            input int n, input bit with_last);
        for (int i = first; i < first + n; i++) begin
            load_pair(bx + 32'(i), bw + 32'(i), with_last && (i == first + n - 1));
        end
    endtask

    task automatic start_vec(input int s, input bit repulse, output int lat);
        int c0;
        int n;
        @(negedge clk);
        go     = 1'b1;
        skew_i = 6'(s);
        c0     = cyc;
        @(negedge clk);
        go = 1'b0;
        if (repulse) begin
            @(negedge clk);
            go     = 1'b1;
            skew_i = 6'd0;
            @(negedge clk);
            go = 1'b0;
        end
        lat = -1;
        n   = 0;
        #1;
        while (!input_start && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (input_start) lat = cyc - c0;
        else fail_wait("input_start_timeout");
    endtask

    task automatic wait_done(input int budget, output int ic);
        int n;
        n  = 0;
        ic = -1;
        @(negedge clk);
        #1;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done) ic = int'(issued_count);
        else fail_wait("done_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x_o"}, x_o, 0);
        chk({tag, "_w_o"}, w_o, 0);
        chk({tag, "_input_start"}, input_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_issued_count"}, issued_count, 0);
        chk({tag, "_ld_ready"}, ld_ready, 1);
    endtask

    initial begin
        int lat;
        int ic;
        int hi;
        n_rst    = 1'b0;
        go       = 1'b0;
        skew_i   = '0;
        ld_valid = 1'b0;
        ld_x     = '0;
        ld_w     = '0;
        ld_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        #2;
        n_rst = 1'b1;

        // 4 pairs, skew 0, PE stalls 3 cycles per op
        pe_stall = 3;
        load_vec(32'h3F80_0000, 32'h4000_0000, 0, 4, 1'b1);
        start_vec(0, 1'b0, lat);
        chk("t2_latency", lat, 1);
        wait_done(200, ic);
        chk("t2_issued", ic, 4);

        // skew 5 with go re-pulsed during SKEW
        pe_stall = 0;
        load_vec(32'h4100_0000, 32'h4140_0000, 0, 2, 1'b1);
        start_vec(5, 1'b1, lat);
        chk("t3_latency", lat, 6);
        wait_done(100, ic);
        chk("t3_issued", ic, 2);

        // fill FIFO, then stream a 40-pair vector through it
        load_vec(32'h4200_0000, 32'h4280_0000, 0, 16, 1'b0);
        chk("t4_full_ld_ready", ld_ready, 0);
        fork
            load_vec(32'h4200_0000, 32'h4280_0000, 16, 24, 1'b1);
            begin
                start_vec(0, 1'b0, lat);
                wait_done(400, ic);
            end
        join
        chk("t4_issued", ic, 40);
        chk("t4_queue_empty", exp_q.size(), 0);

        // underflow bubble between 2nd and 3rd pair
        load_vec(32'h4300_0000, 32'h4380_0000, 0, 2, 1'b0);
        start_vec(0, 1'b0, lat);
        chk("t5_latency", lat, 1);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (input_start) hi++;
        end
        chk("t5_gap_input_start", hi, 0);
        chk("t5_gap_busy", busy, 1);
        load_pair(32'h4300_0002, 32'h4380_0002, 1'b1);
        wait_done(100, ic);
        chk("t5_issued", ic, 3);
        chk("t5_err_clear", err, 0);

        // 65 pairs without last: truncation at 64
        load_vec(32'h4600_0000, 32'hC600_0000, 0, 4, 1'b0);
        fork
            load_vec(32'h4600_0000, 32'hC600_0000, 4, 61, 1'b0);
            begin
                start_vec(0, 1'b0, lat);
                wait_done(400, ic);
            end
        join
        chk("t6_issued", ic, 64);
        chk("t6_err", err, 1);
        @(negedge clk);
        #1;
        chk("t6_busy_idle", busy, 0);
        chk("t6_head_x", x_o, 32'h4600_0040);
        chk("t6_head_w", w_o, 32'hC600_0040);
        chk("t6_queue_left", exp_q.size(), 1);
        chk("t6_err_sticky", err, 1);

        // asynchronous reset while the PE is stalling in ISSUE
        pe_stall = 3;
        load_pair(32'h5000_0000, 32'h5080_0000, 1'b1);
        start_vec(0, 1'b0, lat);
        chk("t1_in_issue", {busy, input_start}, 2'b11);
        #1;
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t1_post_x_o", x_o, 0);
        chk("t1_post_ld_ready", ld_ready, 1);
        chk("t1_post_busy", busy, 0);
        pe_stall = 0;
        load_pair(32'h5100_0000, 32'h5180_0000, 1'b1);
        start_vec(0, 1'b0, lat);
        chk("t1_post_latency", lat, 1);
        wait_done(100, ic);
        chk("t1_post_issued", ic, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
